// File: rtl/fifo_rd_ptr_empty.sv
// Read-domain pointer and status controller for a Gray-pointer async FIFO.
// Tracks the binary read pointer and derives empty, almost-empty, occupancy and underflow flags.
module fifo_rd_ptr_empty #(
  parameter int ADDR_WIDTH = 3,
  parameter int AE_THRESH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RINC,
  input  logic                  UF_CLR,
  input  logic [ADDR_WIDTH:0]   SYNC_WR_PTR,
  output logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [ADDR_WIDTH:0]   GRAY_RD_PTR,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   RD_COUNT,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] AE_LIMIT = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] rd_bin_nxt;
  logic [ADDR_WIDTH:0] rd_gray_nxt;
  logic [ADDR_WIDTH:0] wr_bin;
  logic [ADDR_WIDTH:0] cnt_nxt;
  logic                rd_en;

  assign rd_en       = RINC & ~EMPTY;
  assign rd_bin_nxt  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1);
  assign cnt_nxt     = wr_bin - rd_bin_nxt;
  assign RD_ADDR     = rd_bin[ADDR_WIDTH-1:0];

  // Gray to binary: each bit is the XOR of itself and every more-significant Gray bit.
  always_comb begin
    wr_bin = '0;
    wr_bin[ADDR_WIDTH] = SYNC_WR_PTR[ADDR_WIDTH];
    for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
      wr_bin[ADDR_WIDTH-1-i] = wr_bin[ADDR_WIDTH-i] ^ SYNC_WR_PTR[ADDR_WIDTH-1-i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_bin       <= '0;
      GRAY_RD_PTR  <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      RD_COUNT     <= '0;
      UNDERFLOW    <= 1'b0;
    end else begin
      rd_bin       <= rd_bin_nxt;
      GRAY_RD_PTR  <= rd_gray_nxt;
      EMPTY        <= (rd_gray_nxt == SYNC_WR_PTR);
      ALMOST_EMPTY <= (cnt_nxt <= AE_LIMIT);
      RD_COUNT     <= cnt_nxt;
      if (RINC && EMPTY)
        UNDERFLOW <= 1'b1;
      else if (UF_CLR)
        UNDERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty (ADDR_WIDTH=3, AE_THRESH=2) using directed vectors.
module tb_fifo_rd_ptr_empty;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RINC;
  logic       UF_CLR;
  logic [3:0] SYNC_WR_PTR;
  logic [2:0] RD_ADDR;
  logic [3:0] GRAY_RD_PTR;
  logic       EMPTY;
  logic       ALMOST_EMPTY;
  logic [3:0] RD_COUNT;
  logic       UNDERFLOW;

  fifo_rd_ptr_empty #(.ADDR_WIDTH(3), .AE_THRESH(2)) dut (
    .CLK(CLK), .RST(RST), .RINC(RINC), .UF_CLR(UF_CLR), .SYNC_WR_PTR(SYNC_WR_PTR),
    .RD_ADDR(RD_ADDR), .GRAY_RD_PTR(GRAY_RD_PTR), .EMPTY(EMPTY),
    .ALMOST_EMPTY(ALMOST_EMPTY), .RD_COUNT(RD_COUNT), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] gray;
    logic [2:0] addr;
    logic [3:0] cnt;
    logic       empty;
    logic       ae;
    logic       uf;
    bit         ham;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hand-written 4-bit Gray code, index = binary value.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic check(input string tag, input string field, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h expected=%0h", tag, field, act, exp);
    end
  endtask

  // Monitor: outputs settle after each posedge; compare against the queued expectation at negedge.
  initial begin
    logic [3:0] prev_gray;
    logic [3:0] diff;
    int         ones;
    exp_t       e;
    prev_gray = '0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, "gray",  GRAY_RD_PTR,          e.gray);
        check(e.tag, "addr",  {1'b0, RD_ADDR},      {1'b0, e.addr});
        check(e.tag, "count", RD_COUNT,             e.cnt);
        check(e.tag, "empty", {3'b0, EMPTY},        {3'b0, e.empty});
        check(e.tag, "ae",    {3'b0, ALMOST_EMPTY}, {3'b0, e.ae});
        check(e.tag, "uf",    {3'b0, UNDERFLOW},    {3'b0, e.uf});
        if (e.ham) begin
          diff = prev_gray ^ GRAY_RD_PTR;
          ones = 0;
          for (int b = 0; b < 4; b++) ones += int'(diff[b]);
          check(e.tag, "gray_hamming", 4'(ones), 4'd1);
        end
        prev_gray = GRAY_RD_PTR;
      end
    end
  end

  task automatic step(input string tag, input logic rst_v, input logic rinc_v, input logic clr_v,
                      input logic [3:0] wr_v, input logic [3:0] g, input logic [2:0] a,
                      input logic [3:0] c, input logic e, input logic ae, input logic uf,
                      input bit ham = 1'b0);
    exp_t x;
    RST = rst_v; RINC = rinc_v; UF_CLR = clr_v; SYNC_WR_PTR = wr_v;
    @(posedge CLK);
    x.tag = tag; x.gray = g; x.addr = a; x.cnt = c; x.empty = e; x.ae = ae; x.uf = uf; x.ham = ham;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    int wait_cycles;
    RST = 1'b0; RINC = 1'b0; UF_CLR = 1'b0; SYNC_WR_PTR = '0;

    // 1. reset (RINC during reset must not set underflow)
    step("reset0", 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);
    step("reset1", 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);

    // 2. basic read of 3 entries
    step("wr3",    1, 0, 0, 4'b0010, 4'b0000, 0, 3, 0, 0, 0);
    step("rd1",    1, 1, 0, 4'b0010, 4'b0001, 1, 2, 0, 1, 0);
    step("rd2",    1, 1, 0, 4'b0010, 4'b0011, 2, 1, 0, 1, 0);
    step("rd3",    1, 1, 0, 4'b0010, 4'b0010, 3, 0, 1, 1, 0);

    // 3. underflow set / hold / clear / set-beats-clear
    step("uf_set",  1, 1, 0, 4'b0010, 4'b0010, 3, 0, 1, 1, 1);
    step("uf_hold", 1, 0, 0, 4'b0010, 4'b0010, 3, 0, 1, 1, 1);
    step("uf_clr",  1, 0, 1, 4'b0010, 4'b0010, 3, 0, 1, 1, 0);
    step("uf_both", 1, 1, 1, 4'b0010, 4'b0010, 3, 0, 1, 1, 1);

    // 4. full FIFO, drain, wrap
    step("rst4",   0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);
    step("full",   1, 0, 0, 4'b1100, 4'b0000, 0, 8, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      step("drain8", 1, 1, 0, 4'b1100, gtab[k], 3'(k), 4'(8 - k), (k == 8), (8 - k <= 2), 0);
    step("wr11",   1, 0, 0, 4'b1110, 4'b1100, 0, 3, 0, 0, 0);
    step("wrap9",  1, 1, 0, 4'b1110, 4'b1101, 1, 2, 0, 1, 0);
    step("wrap10", 1, 1, 0, 4'b1110, 4'b1111, 2, 1, 0, 1, 0);
    step("wrap11", 1, 1, 0, 4'b1110, 4'b1110, 3, 0, 1, 1, 0);
    // last-entry read coinciding with a write-pointer advance keeps EMPTY low
    step("wr12",   1, 0, 0, 4'b1010, 4'b1110, 3, 1, 0, 1, 0);
    step("rd_wr",  1, 1, 0, 4'b1011, 4'b1010, 4, 1, 0, 1, 0);

    // 5. reset in the middle of a read
    step("rst5",   0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);
    step("wr5",    1, 0, 0, 4'b0111, 4'b0000, 0, 5, 0, 0, 0);
    step("rd5",    1, 1, 0, 4'b0111, 4'b0001, 1, 4, 0, 0, 0);
    step("rst_mid",0, 1, 0, 4'b0111, 4'b0000, 0, 0, 1, 1, 0);

    // 6. 16 reads with writer kept 4 ahead; every Gray step flips one bit
    step("rst6",   0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);
    step("ahead",  1, 0, 0, gtab[4], 4'b0000, 0, 4, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      step("gray16", 1, 1, 0, gtab[(k + 4) % 16], gtab[k % 16], 3'(k % 8), 4, 0, 0, 0, 1'b1);

    RINC = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge CLK);
      wait_cycles++;
    end
    #6;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ptr_empty.md
Name: fifo_rd_ptr_empty

Overview:
Read-side pointer and flag controller for the async FIFO, in the read clock domain. It consumes the Gray-coded write pointer after the multi-flop synchronizer has brought it into the read domain. It produces the memory read address, the Gray read pointer that is sent back to the write domain, and the empty, almost-empty, occupancy and underflow status. Standard Gray-pointer scheme with one extra MSB for wrap detection.

Parameters:
ADDR_WIDTH, 3, FIFO address width; depth = 2**ADDR_WIDTH
AE_THRESH, 2, ALMOST_EMPTY asserted when occupancy <= AE_THRESH (range 0..2**ADDR_WIDTH)

Ports:
CLK  input  1  read-domain clock, all logic on rising edge
RST  input  1  reset, synchronous, active-low
RINC  input  1  read request; honoured only when EMPTY=0
UF_CLR  input  1  clears sticky UNDERFLOW
SYNC_WR_PTR  input  ADDR_WIDTH+1  Gray write pointer, already synchronized to CLK
RD_ADDR  output  ADDR_WIDTH  memory read address
GRAY_RD_PTR  output  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchronizer
EMPTY  output  1  FIFO empty flag (registered)
ALMOST_EMPTY  output  1  occupancy <= AE_THRESH (registered)
RD_COUNT  output  ADDR_WIDTH+1  occupancy as seen by the read domain, 0..2**ADDR_WIDTH (registered)
UNDERFLOW  output  1  sticky; a read was attempted while EMPTY

Behaviour:
- Reset: on a CLK edge with RST=0, all state is cleared: rd_bin=0, GRAY_RD_PTR=0, EMPTY=1, ALMOST_EMPTY=1, RD_COUNT=0, UNDERFLOW=0. Reset overrides all other inputs, including mid-operation.
- State: rd_bin, an (ADDR_WIDTH+1)-bit binary read pointer.
- Next-pointer logic (combinational):
  - rd_en = RINC & ~EMPTY
  - rd_bin_nxt = rd_bin + rd_en, modulo 2**(ADDR_WIDTH+1)
  - rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1)
- Per clock edge (RST=1):
  - rd_bin <= rd_bin_nxt
  - GRAY_RD_PTR <= rd_gray_nxt
  - EMPTY <= (rd_gray_nxt == SYNC_WR_PTR)
- RD_ADDR = rd_bin[ADDR_WIDTH-1:0], driven directly from the register. Data at RD_ADDR is the head entry; it is consumed on the edge where rd_en=1.
- Occupancy:
  - wr_bin is SYNC_WR_PTR converted from Gray to binary, combinationally (bit i = XOR of Gray bits ADDR_WIDTH..i).
  - cnt_nxt = (wr_bin - rd_bin_nxt) mod 2**(ADDR_WIDTH+1)
  - RD_COUNT <= cnt_nxt
  - ALMOST_EMPTY <= (cnt_nxt <= AE_THRESH)
- Flag latency: EMPTY, ALMOST_EMPTY and RD_COUNT reflect a SYNC_WR_PTR change one CLK later. They reflect a read in the same edge that performs it (no bubble).
- Underflow:
  - RINC=1 while EMPTY=1: pointer unchanged, UNDERFLOW <= 1.
  - Otherwise UF_CLR=1 gives UNDERFLOW <= 0; otherwise it holds.
  - Set wins over a simultaneous UF_CLR.
- Wrap-around: after 2**ADDR_WIDTH reads the pointer MSB toggles while RD_ADDR returns to 0; after 2**(ADDR_WIDTH+1) reads the pointer returns to 0.
- Full FIFO: wr_bin - rd_bin = 2**ADDR_WIDTH gives RD_COUNT = 2**ADDR_WIDTH and EMPTY=0.
- Gray integrity: GRAY_RD_PTR changes by at most one bit per edge.
- SYNC_WR_PTR is trusted; no checking for invalid (multi-step) jumps.
- Simultaneous RINC and a write-pointer advance on the last entry: EMPTY evaluates against the new SYNC_WR_PTR, so it stays 0.

Test Plan (ADDR_WIDTH=3, AE_THRESH=2):
1. Reset: SYNC_WR_PTR=0000, RST=0 for 2 edges -> EMPTY=1, ALMOST_EMPTY=1, RD_COUNT=0, GRAY_RD_PTR=0000, RD_ADDR=0, UNDERFLOW=0.
2. Basic read: SYNC_WR_PTR=0010 (bin 3) -> next edge EMPTY=0, RD_COUNT=3, ALMOST_EMPTY=0. Then RINC=1 for 3 cycles -> RD_ADDR 0,1,2; RD_COUNT 2,1,0; ALMOST_EMPTY=1 after the first read; EMPTY=1 after the third; GRAY_RD_PTR=0010.
3. Underflow: while empty, RINC=1 for 1 cycle -> rd_bin unchanged, UNDERFLOW=1 and stays 1. UF_CLR=1 -> UNDERFLOW=0. RINC=1 and UF_CLR=1 together while empty -> UNDERFLOW=1.
4. Full then wrap:
   - From reset, SYNC_WR_PTR=1100 (bin 8) -> RD_COUNT=8, EMPTY=0.
   - Read 8 -> RD_ADDR 0..7, EMPTY=1, GRAY_RD_PTR=1100.
   - SYNC_WR_PTR=1110 (bin 11) -> RD_COUNT=3.
   - Read 3 -> RD_ADDR 0,1,2, EMPTY=1, GRAY_RD_PTR=1110.
5. Reset mid-operation: RD_COUNT=5, read in progress, RST=0 on one edge -> all outputs at reset values on that edge. RINC is ignored.
6. Gray check: 16 consecutive reads with the write pointer kept ahead -> every GRAY_RD_PTR transition has Hamming distance 1; sequence returns to 0000.
